// File: rtl/traffic_light_monitor.sv
// Traffic light monitor: tracks the A/B signalling phase from the two light
// codes, classifies protocol violations and hands them out one at a time
// through a valid/ready error record with a saturating error counter.
module traffic_light_monitor #(
    parameter int YELLOW_CYCLES = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       la,
    input  logic [1:0]       lb,
    input  logic             mon_en,
    input  logic             err_ready,
    input  logic             err_clr,
    output logic [2:0]       phase,
    output logic             err_valid,
    output logic [2:0]       err_code,
    output logic [2:0]       err_phase,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_ovf
);

    typedef enum logic [2:0] {
        SYNC   = 3'd0,
        A_GO   = 3'd1,
        A_WARN = 3'd2,
        B_GO   = 3'd3,
        B_WARN = 3'd4
    } phase_e;

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_ILLEGAL      = 3'd1,
        ERR_CONFLICT     = 3'd2,
        ERR_BAD_TRANS    = 3'd3,
        ERR_YELLOW_SHORT = 3'd4,
        ERR_YELLOW_LONG  = 3'd5,
        ERR_ALL_RED      = 3'd6
    } err_e;

    localparam logic [1:0]       GREEN   = 2'b00;
    localparam logic [1:0]       YELLOW  = 2'b01;
    localparam logic [1:0]       RED     = 2'b10;
    localparam logic [1:0]       ILLEGAL = 2'b11;
    localparam logic [3:0]       YC      = 4'(YELLOW_CYCLES);
    localparam logic [ERR_W-1:0] CNT_MAX = '1;

    phase_e           phase_q, phase_d;
    logic [3:0]       ycnt_q, ycnt_d;
    logic             err_valid_q, err_valid_d;
    logic [2:0]       err_code_q, err_code_d;
    logic [2:0]       err_phase_q, err_phase_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_ovf_q, err_ovf_d;

    logic   is_ag, is_ay, is_bg, is_by;
    logic   legal, still_yellow, warn_exit;
    logic   err_det, err_accept, err_drop;
    phase_e ok_next;
    err_e   err_sel;

    assign is_ag = (la == GREEN)  && (lb == RED);
    assign is_ay = (la == YELLOW) && (lb == RED);
    assign is_bg = (la == RED)    && (lb == GREEN);
    assign is_by = (la == RED)    && (lb == YELLOW);

    // Phase tracking, yellow timing and prioritised error classification
    always_comb begin
        ok_next      = SYNC;
        legal        = 1'b0;
        still_yellow = 1'b0;
        warn_exit    = 1'b0;
        err_sel      = ERR_NONE;
        phase_d      = SYNC;
        ycnt_d       = 4'd0;

        case (phase_q)
            SYNC: begin
                legal = 1'b1;
                if (is_ag) begin
                    ok_next = A_GO;
                end else if (is_bg) begin
                    ok_next = B_GO;
                end
            end
            A_GO: begin
                if (is_ag) begin
                    legal   = 1'b1;
                    ok_next = A_GO;
                end else if (is_ay) begin
                    legal   = 1'b1;
                    ok_next = A_WARN;
                end
            end
            A_WARN: begin
                still_yellow = is_ay;
                warn_exit    = is_bg;
                if (is_ay) begin
                    legal   = 1'b1;
                    ok_next = A_WARN;
                end else if (is_bg) begin
                    legal   = 1'b1;
                    ok_next = B_GO;
                end
            end
            B_GO: begin
                if (is_bg) begin
                    legal   = 1'b1;
                    ok_next = B_GO;
                end else if (is_by) begin
                    legal   = 1'b1;
                    ok_next = B_WARN;
                end
            end
            B_WARN: begin
                still_yellow = is_by;
                warn_exit    = is_ag;
                if (is_by) begin
                    legal   = 1'b1;
                    ok_next = B_WARN;
                end else if (is_ag) begin
                    legal   = 1'b1;
                    ok_next = A_GO;
                end
            end
            default: begin
                legal   = 1'b0;
                ok_next = SYNC;
            end
        endcase

        if (mon_en && (phase_q != SYNC)) begin
            if ((la == ILLEGAL) || (lb == ILLEGAL)) begin
                err_sel = ERR_ILLEGAL;
            end else if ((la != RED) && (lb != RED)) begin
                err_sel = ERR_CONFLICT;
            end else if ((la == RED) && (lb == RED)) begin
                err_sel = ERR_ALL_RED;
            end else if (still_yellow && (ycnt_q >= YC)) begin
                err_sel = ERR_YELLOW_LONG;
            end else if (warn_exit && (ycnt_q < YC)) begin
                err_sel = ERR_YELLOW_SHORT;
            end else if (!legal) begin
                err_sel = ERR_BAD_TRANS;
            end
        end

        err_det = (err_sel != ERR_NONE);

        if (mon_en && !err_det) begin
            phase_d = ok_next;
        end

        if ((phase_d == A_WARN) || (phase_d == B_WARN)) begin
            if (phase_d == phase_q) begin
                ycnt_d = (ycnt_q == 4'hF) ? ycnt_q : ycnt_q + 4'd1;
            end else begin
                ycnt_d = 4'd1;
            end
        end
    end

    // Error record handshake, drop detection and saturating error counter
    always_comb begin
        err_valid_d = err_valid_q;
        err_code_d  = err_code_q;
        err_phase_d = err_phase_q;
        err_cnt_d   = err_cnt_q;
        err_ovf_d   = err_ovf_q;

        err_accept = err_det && (!err_valid_q || err_ready);
        err_drop   = err_det && err_valid_q && !err_ready;

        if (err_accept) begin
            err_valid_d = 1'b1;
            err_code_d  = err_sel;
            err_phase_d = phase_q;
        end else if (err_ready) begin
            err_valid_d = 1'b0;
        end

        if (err_clr) begin
            err_cnt_d = err_det ? ERR_W'(1) : '0;
            err_ovf_d = err_drop;
        end else begin
            if (err_det && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            err_ovf_d = err_ovf_q | err_drop;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= SYNC;
            ycnt_q      <= 4'd0;
            err_valid_q <= 1'b0;
            err_code_q  <= 3'd0;
            err_phase_q <= 3'd0;
            err_cnt_q   <= '0;
            err_ovf_q   <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            ycnt_q      <= ycnt_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_phase_q <= err_phase_d;
            err_cnt_q   <= err_cnt_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    assign phase     = phase_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign err_phase = err_phase_q;
    assign err_cnt   = err_cnt_q;
    assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Testbench for traffic_light_monitor: one default instance plus one with a
// longer yellow phase and a narrow counter; expected outputs for each step
// are queued when stimulus is applied and popped after the clock edge.
module tb_traffic_light_monitor;

    typedef struct packed {
        logic [2:0] phase;
        logic       valid;
        logic [2:0] code;
        logic [2:0] ephase;
        logic [7:0] cnt;
        logic       ovf;
    } obs_t;

    typedef struct {
        logic       rst;
        logic       en;
        logic       rdy;
        logic       clr;
        logic [3:0] pr;
        obs_t       exp;
    } step_t;

    // {la, lb} light pairs
    localparam logic [3:0] P_AG = 4'b0010;
    localparam logic [3:0] P_AY = 4'b0110;
    localparam logic [3:0] P_BG = 4'b1000;
    localparam logic [3:0] P_BY = 4'b1001;
    localparam logic [3:0] P_CF = 4'b0000;
    localparam logic [3:0] P_AR = 4'b1010;
    localparam logic [3:0] P_IL = 4'b1100;
    localparam logic [3:0] P_XX = 4'b1111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] la = 2'b10;
    logic [1:0] lb = 2'b10;
    logic       mon_en = 1'b1;
    logic       err_ready = 1'b0;
    logic       err_clr = 1'b0;

    logic [2:0] phase1, err_code1, err_phase1;
    logic       err_valid1, err_ovf1;
    logic [7:0] err_cnt1;
    logic [2:0] phase2, err_code2, err_phase2;
    logic       err_valid2, err_ovf2;
    logic [1:0] err_cnt2;

    int   n_cmp = 0;
    int   n_err = 0;
    obs_t exp_q[$];

    traffic_light_monitor dut (
        .clk(clk), .rst(rst), .la(la), .lb(lb), .mon_en(mon_en),
        .err_ready(err_ready), .err_clr(err_clr),
        .phase(phase1), .err_valid(err_valid1), .err_code(err_code1),
        .err_phase(err_phase1), .err_cnt(err_cnt1), .err_ovf(err_ovf1)
    );

    traffic_light_monitor #(.YELLOW_CYCLES(3), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .la(la), .lb(lb), .mon_en(mon_en),
        .err_ready(err_ready), .err_clr(err_clr),
        .phase(phase2), .err_valid(err_valid2), .err_code(err_code2),
        .err_phase(err_phase2), .err_cnt(err_cnt2), .err_ovf(err_ovf2)
    );

    always #5 clk = ~clk;

    function automatic step_t mk(input bit r, input bit en, input bit rdy, input bit clr,
                                 input logic [3:0] pr, input int ph, input int v,
                                 input int c, input int ep, input int cnt, input int ovf);
        step_t s;
        s.rst        = r;
        s.en         = en;
        s.rdy        = rdy;
        s.clr        = clr;
        s.pr         = pr;
        s.exp.phase  = 3'(ph);
        s.exp.valid  = 1'(v);
        s.exp.code   = 3'(c);
        s.exp.ephase = 3'(ep);
        s.exp.cnt    = 8'(cnt);
        s.exp.ovf    = 1'(ovf);
        return s;
    endfunction

    function automatic obs_t obs1();
        obs_t o;
        o.phase  = phase1;
        o.valid  = err_valid1;
        o.code   = err_code1;
        o.ephase = err_phase1;
        o.cnt    = err_cnt1;
        o.ovf    = err_ovf1;
        return o;
    endfunction

    function automatic obs_t obs2();
        obs_t o;
        o.phase  = phase2;
        o.valid  = err_valid2;
        o.code   = err_code2;
        o.ephase = err_phase2;
        o.cnt    = {6'd0, err_cnt2};
        o.ovf    = err_ovf2;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("ph=%0d v=%0d code=%0d eph=%0d cnt=%0d ovf=%0d",
                         o.phase, o.valid, o.code, o.ephase, o.cnt, o.ovf);
    endfunction

    task automatic apply_stimulus(input step_t s);
        rst       = s.rst;
        mon_en    = s.en;
        err_ready = s.rdy;
        err_clr   = s.clr;
        la        = s.pr[3:2];
        lb        = s.pr[1:0];
        exp_q.push_back(s.exp);
    endtask

    task automatic test_reset();
        step_t s[$];
        obs_t  got, exp;
        s.push_back(mk(1, 1, 0, 0, P_AG, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(1, 1, 1, 1, P_IL, 0, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            apply_stimulus(s[i]);
            @(posedge clk); #1;
            got = obs1();
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("[TB] FAIL reset[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_normal_cycle();
        step_t s[$];
        obs_t  got, exp;
        s.push_back(mk(1, 1, 1, 0, P_AG, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 1, 0, P_AG, 1, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 1, 0, P_AG, 1, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 1, 0, P_AG, 1, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 1, 0, P_AY, 2, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 1, 0, P_BG, 3, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 1, 0, P_BG, 3, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 1, 0, P_BY, 4, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 1, 0, P_AG, 1, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            apply_stimulus(s[i]);
            @(posedge clk); #1;
            got = obs1();
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("[TB] FAIL normal[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_conflict();
        step_t s[$];
        obs_t  got, exp;
        s.push_back(mk(1, 1, 0, 0, P_AG, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 0, P_AG, 1, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 0, P_CF, 0, 1, 2, 1, 1, 0));
        s.push_back(mk(0, 1, 0, 0, P_BG, 3, 1, 2, 1, 1, 0));
        s.push_back(mk(0, 1, 1, 0, P_AR, 0, 1, 6, 3, 2, 0));
        s.push_back(mk(0, 1, 1, 0, P_AR, 0, 0, 6, 3, 2, 0));
        foreach (s[i]) begin
            apply_stimulus(s[i]);
            @(posedge clk); #1;
            got = obs1();
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("[TB] FAIL conflict[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_yellow_long();
        step_t s[$];
        obs_t  got, exp;
        s.push_back(mk(1, 1, 0, 0, P_AG, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 0, P_AG, 1, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 0, P_AY, 2, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 0, P_AY, 0, 1, 5, 2, 1, 0));
        foreach (s[i]) begin
            apply_stimulus(s[i]);
            @(posedge clk); #1;
            got = obs1();
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("[TB] FAIL ylong[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_bad_transition();
        step_t s[$];
        obs_t  got, exp;
        s.push_back(mk(1, 1, 1, 0, P_AG, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 1, 0, P_BG, 3, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 1, 0, P_AG, 0, 1, 3, 3, 1, 0));
        s.push_back(mk(0, 1, 1, 0, P_AG, 1, 0, 3, 3, 1, 0));
        s.push_back(mk(0, 1, 1, 0, P_IL, 0, 1, 1, 1, 2, 0));
        s.push_back(mk(0, 1, 1, 0, P_XX, 0, 0, 1, 1, 2, 0));
        s.push_back(mk(0, 1, 1, 0, P_AG, 1, 0, 1, 1, 2, 0));
        s.push_back(mk(0, 1, 1, 0, P_AY, 2, 0, 1, 1, 2, 0));
        s.push_back(mk(0, 1, 1, 0, P_AG, 0, 1, 3, 2, 3, 0));
        foreach (s[i]) begin
            apply_stimulus(s[i]);
            @(posedge clk); #1;
            got = obs1();
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("[TB] FAIL badtrans[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        obs_t  got, exp;
        s.push_back(mk(1, 1, 0, 0, P_AG, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 0, P_AG, 1, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 0, P_CF, 0, 1, 2, 1, 1, 0));
        s.push_back(mk(0, 1, 0, 0, P_AG, 1, 1, 2, 1, 1, 0));
        s.push_back(mk(0, 1, 0, 0, P_AR, 0, 1, 2, 1, 2, 1));
        s.push_back(mk(0, 1, 0, 1, P_AR, 0, 1, 2, 1, 0, 0));
        s.push_back(mk(0, 1, 1, 0, P_AR, 0, 0, 2, 1, 0, 0));
        s.push_back(mk(0, 1, 0, 0, P_AG, 1, 0, 2, 1, 0, 0));
        s.push_back(mk(0, 1, 0, 1, P_CF, 0, 1, 2, 1, 1, 0));
        s.push_back(mk(0, 1, 0, 0, P_AG, 1, 1, 2, 1, 1, 0));
        s.push_back(mk(0, 1, 0, 1, P_CF, 0, 1, 2, 1, 1, 1));
        foreach (s[i]) begin
            apply_stimulus(s[i]);
            @(posedge clk); #1;
            got = obs1();
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("[TB] FAIL backtoback[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_mon_en();
        step_t s[$];
        obs_t  got, exp;
        s.push_back(mk(1, 1, 0, 0, P_AG, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 0, P_AG, 1, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, P_AG, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, P_CF, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 0, P_AG, 1, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 0, P_CF, 0, 1, 2, 1, 1, 0));
        s.push_back(mk(0, 0, 1, 0, P_CF, 0, 0, 2, 1, 1, 0));
        foreach (s[i]) begin
            apply_stimulus(s[i]);
            @(posedge clk); #1;
            got = obs1();
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("[TB] FAIL monen[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t s[$];
        obs_t  got, exp;
        s.push_back(mk(1, 1, 0, 0, P_AG, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 0, P_AG, 1, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 0, P_CF, 0, 1, 2, 1, 1, 0));
        s.push_back(mk(0, 1, 0, 0, P_AG, 1, 1, 2, 1, 1, 0));
        s.push_back(mk(0, 1, 0, 0, P_AY, 2, 1, 2, 1, 1, 0));
        s.push_back(mk(1, 1, 0, 0, P_AY, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 0, P_AY, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 0, P_AG, 1, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            apply_stimulus(s[i]);
            @(posedge clk); #1;
            got = obs1();
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("[TB] FAIL resetmid[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    // 256 conflicts, each from A_GO; the 8-bit counter must stop at 255
    task automatic test_cnt_saturate();
        obs_t got, exp;
        int   want;
        apply_stimulus(mk(1, 1, 1, 0, P_AG, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        void'(exp_q.pop_front());
        for (int i = 0; i < 256; i++) begin
            want = (i + 1 > 255) ? 255 : i + 1;
            apply_stimulus(mk(0, 1, 1, 0, P_AG, 1, 0, 0, 0, 0, 0));
            @(posedge clk); #1;
            void'(exp_q.pop_front());
            apply_stimulus(mk(0, 1, 1, 0, P_CF, 0, 1, 2, 1, want, 0));
            @(posedge clk); #1;
            got = obs1();
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("[TB] FAIL cntsat[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    // Second instance: YELLOW_CYCLES=3, ERR_W=2
    task automatic test_yellow_timing();
        step_t s[$];
        obs_t  got, exp;
        s.push_back(mk(1, 1, 1, 0, P_AG, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 1, 0, P_AG, 1, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 1, 0, P_AY, 2, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 1, 0, P_AY, 2, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 1, 0, P_BG, 0, 1, 4, 2, 1, 0));
        s.push_back(mk(0, 1, 1, 0, P_BG, 3, 0, 4, 2, 1, 0));
        s.push_back(mk(0, 1, 1, 0, P_BY, 4, 0, 4, 2, 1, 0));
        s.push_back(mk(0, 1, 1, 0, P_BY, 4, 0, 4, 2, 1, 0));
        s.push_back(mk(0, 1, 1, 0, P_BY, 4, 0, 4, 2, 1, 0));
        s.push_back(mk(0, 1, 1, 0, P_AG, 1, 0, 4, 2, 1, 0));
        s.push_back(mk(0, 1, 1, 0, P_AY, 2, 0, 4, 2, 1, 0));
        s.push_back(mk(0, 1, 1, 0, P_AY, 2, 0, 4, 2, 1, 0));
        s.push_back(mk(0, 1, 1, 0, P_AY, 2, 0, 4, 2, 1, 0));
        s.push_back(mk(0, 1, 1, 0, P_AY, 0, 1, 5, 2, 2, 0));
        s.push_back(mk(0, 1, 1, 0, P_AG, 1, 0, 5, 2, 2, 0));
        s.push_back(mk(0, 1, 1, 0, P_CF, 0, 1, 2, 1, 3, 0));
        s.push_back(mk(0, 1, 1, 0, P_AG, 1, 0, 2, 1, 3, 0));
        s.push_back(mk(0, 1, 1, 0, P_CF, 0, 1, 2, 1, 3, 0));
        foreach (s[i]) begin
            apply_stimulus(s[i]);
            @(posedge clk); #1;
            got = obs2();
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("[TB] FAIL ytiming[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    // Run all scenarios in order, then report
    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_normal_cycle();
        test_conflict();
        test_yellow_long();
        test_bad_transition();
        test_back_to_back();
        test_mon_en();
        test_reset_mid();
        test_cnt_saturate();
        test_yellow_timing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run cannot hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] time limit");
    end

endmodule
